regfile_serial_dump: RTL

//  Reader-side companion to the 8x8 register file. On a START pulse it walks

---
 rtl/regfile_serial_dump.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_serial_dump.sv
// Walks register file read port A and streams each byte out as an 8N1
// serial frame, LSB first, for offline inspection of working registers.
module regfile_serial_dump #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 8,
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic [ADDR_W-1:0] RF_SA,
  input  logic [DATA_W-1:0] RF_DATA,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE
);

  localparam int BAUD_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] SA_LAST =
    ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   shift_nxt;
  logic                baud_end;

  assign baud_end  = (baud == BAUD_LAST);
  assign shift_nxt = shift >> 1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      TX      <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RF_SA   <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          TX      <= 1'b1;
          baud    <= '0;
          bit_cnt <= '0;
          if (START) begin
            state <= FETCH;
            BUSY  <= 1'b1;
            RF_SA <= '0;
          end
        end

        // Snapshot the byte; later writes cannot corrupt this frame.
        FETCH: begin
          shift <= RF_DATA;
          TX    <= 1'b0;
          baud  <= '0;
          state <= START_BIT;
        end

        START_BIT: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            TX      <= shift[0];
            state   <= DATA_BITS;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        DATA_BITS: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
              TX    <= 1'b1;
              state <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift_nxt;
              TX      <= shift_nxt[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        // RF_SA parks on the last register until the next dump.
        STOP_BIT: begin
          TX <= 1'b1;
          if (baud_end) begin
            baud <= '0;
            if (RF_SA == SA_LAST) begin
              state <= IDLE;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              RF_SA <= RF_SA + 1'b1;
              state <= FETCH;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
